main_memory_ws: RTL and testbench
=================================

Name: main_memory_ws

Overview:
Parametrised main-memory block for the uDATAPATH / Centro_Control system. It is the successor to the fixed MAIN_MEMORY. It generalises data width, address width, depth and wait-state count. It adds a 4-phase RD/WR/ACK handshake, a busy indication and an error flag for illegal requests. Address comes from bus A, write data from bus B, and read data goes to the bus-C mux; RD/WR/ACK connect to Centro_Control.

Parameters:
DATAWIDTH_BUS, 32, data and address bus width.
ADDRWIDTH, 8, number of address bits decoded.
DEPTH, 256, words implemented; must satisfy DEPTH <= 2**ADDRWIDTH.
WAIT_STATES, 2, extra cycles between request acceptance and access; 0 is legal.

Ports:
MAIN_MEMORY_WS_CLOCK_50  in  1  single system clock, rising edge.
MAIN_MEMORY_WS_RESET_InLow  in  1  asynchronous, active-low reset.
MAIN_MEMORY_WS_ADDRESS_InBUS  in  DATAWIDTH_BUS  word address.
MAIN_MEMORY_WS_data_InBUS  in  DATAWIDTH_BUS  write data.
MAIN_MEMORY_WS_RD_In  in  1  read request, level.
MAIN_MEMORY_WS_WR_In  in  1  write request, level.
MAIN_MEMORY_WS_data_OutBUS  out  DATAWIDTH_BUS  read data, registered.
MAIN_MEMORY_WS_ACK_Out  out  1  access complete.
MAIN_MEMORY_WS_BUSY_Out  out  1  request accepted, not yet acknowledged.
MAIN_MEMORY_WS_ERROR_Out  out  1  current ACK reports an illegal request.

Behaviour:
- Reset (asynchronous assert, synchronous-release use):
  - state=IDLE; data_OutBUS=0; ACK=0; BUSY=0; ERROR=0; wait counter=0.
  - Array contents are not cleared.
- States: IDLE, BUSY, ACK.
- IDLE:
  - If RD|WR is sampled high at an edge: capture address, data, RD, WR; load counter=WAIT_STATES; go to BUSY; BUSY=1.
  - Otherwise stay in IDLE.
- BUSY:
  - Counter≠0: decrement.
  - Counter==0: perform the access, go to ACK; ACK=1, BUSY=0.
  - ACK therefore rises WAIT_STATES+1 cycles after the accepting edge.
- Access rules:
  - Read: data_OutBUS <= mem[addr].
  - Write: mem[addr] <= captured data; data_OutBUS is unchanged.
  - Commit occurs only on the BUSY->ACK edge.
- Illegal request, checked on captured values: RD&WR both high, addr >= DEPTH, or any address bit at or above ADDRWIDTH nonzero.
  - No array write; data_OutBUS <= 0; ERROR=1 together with ACK.
- ACK (4-phase handshake):
  - ACK is held at 1 and data_OutBUS held stable while RD|WR remains high.
  - When RD|WR is sampled low: ACK=0, ERROR=0, go to IDLE.
  - A new request is accepted no earlier than the edge after the return to IDLE.
- Request changes during BUSY are ignored; captured values rule.
- Reset during BUSY aborts the access: no write commit, and no ACK is issued.
- WAIT_STATES=0 gives minimum latency: ACK rises at the edge following acceptance.
- Counter width: $clog2(WAIT_STATES+1), minimum 1.

Optional Feature:
MAIN_MEMORY_WS_BYTEMASK_EN
- Defined: adds input port MAIN_MEMORY_WS_BYTEEN_InBUS [DATAWIDTH_BUS/8], captured at acceptance. A write updates only the byte lanes whose bit is 1; mask 0 makes the write a no-op that is still ACKed. Reads ignore the mask. DATAWIDTH_BUS must be a multiple of 8.
- Undefined: port absent; all writes are full-word.

Decomposition:
- Package main_memory_ws_pkg:
  - state enum (IDLE/BUSY/ACK);
  - localparam for counter-width computation;
  - illegal-request check function.
- Sub-module main_memory_ws_array: storage with synchronous write (optional lane mask) and registered read port.
- The top holds the FSM, counter, capture registers and error logic.

Test Plan:
- Reset, then WR addr=0x05 data=0xDEADBEEF, WAIT_STATES=2 -> ACK rises 3 cycles after acceptance. Drop WR -> ACK falls. RD addr=0x05 -> data_OutBUS=0xDEADBEEF with ACK, ERROR=0.
- WAIT_STATES=0 build, RD held high after ACK -> ACK stays 1 and data stable; no second access until RD goes low and then high again.
- RD&WR both high at addr=0x10 -> ACK with ERROR=1, data_OutBUS=0; a later RD of 0x10 returns the prior contents unchanged.
- Address 0x100 (ADDRWIDTH=8) and DEPTH=200 with addr=0xC8 -> each gives ERROR=1; no write occurs.
- Reset pulled low during BUSY of a write to 0x07 (old value 0x11111111) -> outputs return to reset values; a subsequent read returns 0x11111111.
- BYTEMASK_EN: write 0xAABBCCDD with mask 4'b0101 over 0x00000000 -> a read returns 0x00BB00DD.

Source files
------------

// File: rtl/main_memory_ws_pkg.sv
// main_memory_ws_pkg: shared state type, counter sizing and request legality
// check for the wait-state main memory (main_memory_ws).
// Optional feature macro: MAIN_MEMORY_WS_BYTEMASK_EN (byte-lane write mask).
package main_memory_ws_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_ACK  = 2'd2
  } mmState_t;

  // Narrowest counter ever built, even when WAIT_STATES is 0.
  localparam int MIN_CNT_WIDTH = 1;

  // Widest bus the legality check understands; addresses are zero-extended to it.
  localparam int MAX_BUS_WIDTH = 64;

  // Bits needed to hold the values 0..waitStates, never below MIN_CNT_WIDTH.
  function automatic int counterWidth(input int waitStates);
    int w;
    w = $clog2(waitStates + 1);
    return (w < MIN_CNT_WIDTH) ? MIN_CNT_WIDTH : w;
  endfunction

  // A request is illegal when it asks for read and write at once, addresses
  // past the implemented depth, or sets any bit above the decoded field.
  function automatic logic isIllegalReq(
    input logic                     rdReq,
    input logic                     wrReq,
    input logic [MAX_BUS_WIDTH-1:0] addr,
    input int                       addrWidth,
    input int                       depth
  );
    logic [MAX_BUS_WIDTH-1:0] depthW;
    logic                     highBits;
    logic                     outOfRange;
    depthW     = MAX_BUS_WIDTH'(depth);
    highBits   = (addrWidth < MAX_BUS_WIDTH) ? ((addr >> addrWidth) != '0) : 1'b0;
    outOfRange = (addr >= depthW);
    return (rdReq & wrReq) | highBits | outOfRange;
  endfunction

endpackage

// File: rtl/main_memory_ws_array.sv
// main_memory_ws_array: word storage with a synchronous, lane-masked write
// port and a registered read port. The read register can be forced to zero
// so that a rejected request returns a clean all-zero word.
module main_memory_ws_array #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int IDX_W  = 8,
  parameter int LANE_W = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wrEn,
  input  logic                     rdEn,
  input  logic                     clrEn,
  input  logic [IDX_W-1:0]         addr,
  input  logic [DATA_W-1:0]        wrData,
  input  logic [DATA_W/LANE_W-1:0] laneMask,
  output logic [DATA_W-1:0]        rdData
);

  localparam int NUM_LANES = DATA_W / LANE_W;

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [DATA_W-1:0] rdData_r;

  // Storage write: only lanes selected by the mask are updated; no reset so
  // contents survive a reset of the control logic.
  always_ff @(posedge clk) begin
    if (wrEn) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (laneMask[i]) begin
          mem_r[addr][i*LANE_W +: LANE_W] <= wrData[i*LANE_W +: LANE_W];
        end
      end
    end
  end

  // Read register: cleared on reset or rejection, loaded on a legal read, held otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdData_r <= '0;
    end else if (clrEn) begin
      rdData_r <= '0;
    end else if (rdEn) begin
      rdData_r <= mem_r[addr];
    end else begin
      rdData_r <= rdData_r;
    end
  end

  assign rdData = rdData_r;

endmodule

// File: rtl/main_memory_ws.sv
// main_memory_ws: parametrised main memory with programmable wait states and a
// 4-phase RD/WR/ACK handshake. A request is captured in IDLE, waits
// WAIT_STATES cycles in BUSY, is committed on the BUSY->ACK edge, and ACK is
// held until the requester drops RD/WR. Illegal requests are ACKed with ERROR
// and return zero data without touching the array.
// Optional feature macro: MAIN_MEMORY_WS_BYTEMASK_EN adds a per-byte write
// mask port (DATAWIDTH_BUS must then be a multiple of 8).
// DATAWIDTH_BUS is expected to be at most 64 (legality check width).
module main_memory_ws
  import main_memory_ws_pkg::*;
#(
  parameter int DATAWIDTH_BUS = 32,
  parameter int ADDRWIDTH     = 8,
  parameter int DEPTH         = 256,
  parameter int WAIT_STATES   = 2
) (
  input  logic                       MAIN_MEMORY_WS_CLOCK_50,
  input  logic                       MAIN_MEMORY_WS_RESET_InLow,
  input  logic [DATAWIDTH_BUS-1:0]   MAIN_MEMORY_WS_ADDRESS_InBUS,
  input  logic [DATAWIDTH_BUS-1:0]   MAIN_MEMORY_WS_data_InBUS,
  input  logic                       MAIN_MEMORY_WS_RD_In,
  input  logic                       MAIN_MEMORY_WS_WR_In,
`ifdef MAIN_MEMORY_WS_BYTEMASK_EN
  input  logic [DATAWIDTH_BUS/8-1:0] MAIN_MEMORY_WS_BYTEEN_InBUS,
`endif
  output logic [DATAWIDTH_BUS-1:0]   MAIN_MEMORY_WS_data_OutBUS,
  output logic                       MAIN_MEMORY_WS_ACK_Out,
  output logic                       MAIN_MEMORY_WS_BUSY_Out,
  output logic                       MAIN_MEMORY_WS_ERROR_Out
);

  localparam int CNT_W = counterWidth(WAIT_STATES);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef MAIN_MEMORY_WS_BYTEMASK_EN
  localparam int LANE_W = 8;
`else
  localparam int LANE_W = DATAWIDTH_BUS;
`endif
  localparam int NUM_LANES = DATAWIDTH_BUS / LANE_W;

  logic clk;
  logic rst_n;
  assign clk   = MAIN_MEMORY_WS_CLOCK_50;
  assign rst_n = MAIN_MEMORY_WS_RESET_InLow;

  mmState_t                 state_r, nextState_s;
  logic [CNT_W-1:0]         cnt_r, nextCnt_s;
  logic [DATAWIDTH_BUS-1:0] captAddr_r, captData_r;
  logic                     captRd_r, captWr_r;
  logic [NUM_LANES-1:0]     captMask_r, reqMask_s;
  logic                     ack_r, nextAck_s;
  logic                     busy_r, nextBusy_s;
  logic                     err_r, nextErr_s;
  logic                     reqActive_s, capture_s, access_s;
  logic                     illegal_s, memWrEn_s, memRdEn_s, memClr_s;

  assign reqActive_s = MAIN_MEMORY_WS_RD_In | MAIN_MEMORY_WS_WR_In;

`ifdef MAIN_MEMORY_WS_BYTEMASK_EN
  assign reqMask_s = MAIN_MEMORY_WS_BYTEEN_InBUS;
`else
  assign reqMask_s = '1;
`endif

  // State, wait counter and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= '0;
      ack_r   <= 1'b0;
      busy_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      state_r <= nextState_s;
      cnt_r   <= nextCnt_s;
      ack_r   <= nextAck_s;
      busy_r  <= nextBusy_s;
      err_r   <= nextErr_s;
    end
  end

  // Request capture: address, data, direction and mask frozen at acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      captAddr_r <= '0;
      captData_r <= '0;
      captRd_r   <= 1'b0;
      captWr_r   <= 1'b0;
      captMask_r <= '0;
    end else if (capture_s) begin
      captAddr_r <= MAIN_MEMORY_WS_ADDRESS_InBUS;
      captData_r <= MAIN_MEMORY_WS_data_InBUS;
      captRd_r   <= MAIN_MEMORY_WS_RD_In;
      captWr_r   <= MAIN_MEMORY_WS_WR_In;
      captMask_r <= reqMask_s;
    end else begin
      captAddr_r <= captAddr_r;
      captData_r <= captData_r;
      captRd_r   <= captRd_r;
      captWr_r   <= captWr_r;
      captMask_r <= captMask_r;
    end
  end

  // Next-state logic: accept in IDLE, count down in BUSY, hold ACK until release.
  always_comb begin
    nextState_s = state_r;
    nextCnt_s   = cnt_r;
    nextAck_s   = ack_r;
    nextBusy_s  = busy_r;
    nextErr_s   = err_r;
    capture_s   = 1'b0;
    access_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (reqActive_s) begin
          capture_s   = 1'b1;
          nextCnt_s   = CNT_W'(WAIT_STATES);
          nextState_s = ST_BUSY;
          nextBusy_s  = 1'b1;
        end else begin
          nextState_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (cnt_r != '0) begin
          nextCnt_s = cnt_r - CNT_W'(1);
        end else begin
          access_s    = 1'b1;
          nextState_s = ST_ACK;
          nextAck_s   = 1'b1;
          nextBusy_s  = 1'b0;
          nextErr_s   = illegal_s;
        end
      end
      ST_ACK: begin
        if (!reqActive_s) begin
          nextState_s = ST_IDLE;
          nextAck_s   = 1'b0;
          nextErr_s   = 1'b0;
        end else begin
          nextState_s = ST_ACK;
        end
      end
      default: begin
        nextState_s = ST_IDLE;
        nextCnt_s   = '0;
        nextAck_s   = 1'b0;
        nextBusy_s  = 1'b0;
        nextErr_s   = 1'b0;
      end
    endcase
  end

  // Access decode: legality of the captured request gates the array strobes.
  always_comb begin
    illegal_s = isIllegalReq(captRd_r, captWr_r, MAX_BUS_WIDTH'(captAddr_r),
                             ADDRWIDTH, DEPTH);
    memWrEn_s = access_s & captWr_r & ~illegal_s;
    memRdEn_s = access_s & captRd_r & ~illegal_s;
    memClr_s  = access_s & illegal_s;
  end

  main_memory_ws_array #(
    .DATA_W (DATAWIDTH_BUS),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W),
    .LANE_W (LANE_W)
  ) u_array (
    .clk      (clk),
    .rst_n    (rst_n),
    .wrEn     (memWrEn_s),
    .rdEn     (memRdEn_s),
    .clrEn    (memClr_s),
    .addr     (captAddr_r[IDX_W-1:0]),
    .wrData   (captData_r),
    .laneMask (captMask_r),
    .rdData   (MAIN_MEMORY_WS_data_OutBUS)
  );

  assign MAIN_MEMORY_WS_ACK_Out   = ack_r;
  assign MAIN_MEMORY_WS_BUSY_Out  = busy_r;
  assign MAIN_MEMORY_WS_ERROR_Out = err_r;

endmodule

// File: tb/tb_main_memory_ws.sv
// tb_main_memory_ws: two instances (2 wait states / depth 256 and 0 wait
// states / depth 200) share one stimulus stream. A transaction-level model
// per instance predicts ACK/BUSY/ERROR/data every cycle; directed handshakes
// pin latency, error and data values with literal expectations.
module tb_main_memory_ws;

  localparam int WS0 = 2;
  localparam int WS1 = 0;
  localparam int DEP0 = 256;
  localparam int DEP1 = 200;
  localparam int AW = 8;
`ifdef MAIN_MEMORY_WS_BYTEMASK_EN
  localparam bit BM = 1'b1;
`else
  localparam bit BM = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic [3:0]  be = 4'hF;
  logic [31:0] dout0, dout1;
  logic        ack0, ack1, busy0, busy1, err0, err1;

  int checks = 0;
  int errors = 0;
  bit checkEn = 1'b0;

  always #5 clk = ~clk;

  main_memory_ws #(.DATAWIDTH_BUS(32), .ADDRWIDTH(AW), .DEPTH(DEP0), .WAIT_STATES(WS0)) dut0 (
    .MAIN_MEMORY_WS_CLOCK_50      (clk),
    .MAIN_MEMORY_WS_RESET_InLow   (rst_n),
    .MAIN_MEMORY_WS_ADDRESS_InBUS (addr),
    .MAIN_MEMORY_WS_data_InBUS    (wdata),
    .MAIN_MEMORY_WS_RD_In         (rd),
    .MAIN_MEMORY_WS_WR_In         (wr),
`ifdef MAIN_MEMORY_WS_BYTEMASK_EN
    .MAIN_MEMORY_WS_BYTEEN_InBUS  (be),
`endif
    .MAIN_MEMORY_WS_data_OutBUS   (dout0),
    .MAIN_MEMORY_WS_ACK_Out       (ack0),
    .MAIN_MEMORY_WS_BUSY_Out      (busy0),
    .MAIN_MEMORY_WS_ERROR_Out     (err0)
  );

  main_memory_ws #(.DATAWIDTH_BUS(32), .ADDRWIDTH(AW), .DEPTH(DEP1), .WAIT_STATES(WS1)) dut1 (
    .MAIN_MEMORY_WS_CLOCK_50      (clk),
    .MAIN_MEMORY_WS_RESET_InLow   (rst_n),
    .MAIN_MEMORY_WS_ADDRESS_InBUS (addr),
    .MAIN_MEMORY_WS_data_InBUS    (wdata),
    .MAIN_MEMORY_WS_RD_In         (rd),
    .MAIN_MEMORY_WS_WR_In         (wr),
`ifdef MAIN_MEMORY_WS_BYTEMASK_EN
    .MAIN_MEMORY_WS_BYTEEN_InBUS  (be),
`endif
    .MAIN_MEMORY_WS_data_OutBUS   (dout1),
    .MAIN_MEMORY_WS_ACK_Out       (ack1),
    .MAIN_MEMORY_WS_BUSY_Out      (busy1),
    .MAIN_MEMORY_WS_ERROR_Out     (err1)
  );

  // ---------------- transaction-level reference model ----------------
  int          cyc = 0;
  int          mDue [2];
  bit          mPend [2], mAck [2], mErr [2], mKnownOut [2];
  logic [31:0] mDout [2];
  logic [31:0] cAddr [2], cData [2];
  bit          cRd [2], cWr [2];
  logic [3:0]  cBe [2];
  logic [31:0] mMem [2][256];
  logic [3:0]  mKb [2][256];

  initial begin
    for (int k = 0; k < 2; k++) begin
      mPend[k] = 1'b0; mAck[k] = 1'b0; mErr[k] = 1'b0;
      mDout[k] = 32'd0; mKnownOut[k] = 1'b1; mDue[k] = 0;
      for (int j = 0; j < 256; j++) mKb[k][j] = 4'h0;
    end
  end

  task automatic commit(input int k);
    logic [31:0] a;
    int          dep;
    int          ai;
    bit          bad;
    logic [3:0]  msk;
    a   = cAddr[k];
    dep = (k == 0) ? DEP0 : DEP1;
    bad = (cRd[k] && cWr[k]) || (a >= 32'(dep)) || (a >= (32'd1 << AW));
    if (bad) begin
      mErr[k] = 1'b1;
      mDout[k] = 32'd0;
      mKnownOut[k] = 1'b1;
    end else begin
      ai = int'(a[7:0]);
      if (cRd[k]) begin
        mDout[k] = mMem[k][ai];
        mKnownOut[k] = (mKb[k][ai] == 4'hF);
      end else begin
        msk = BM ? cBe[k] : 4'hF;
        for (int b = 0; b < 4; b++) begin
          if (msk[b]) begin
            mMem[k][ai][8*b +: 8] = cData[k][8*b +: 8];
            mKb[k][ai][b] = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic modelStep(input int k);
    if (!rst_n) begin
      mPend[k] = 1'b0; mAck[k] = 1'b0; mErr[k] = 1'b0;
      mDout[k] = 32'd0; mKnownOut[k] = 1'b1;
    end else if (mAck[k]) begin
      if (!(rd || wr)) begin
        mAck[k] = 1'b0;
        mErr[k] = 1'b0;
      end
    end else if (mPend[k]) begin
      if (cyc == mDue[k]) begin
        commit(k);
        mPend[k] = 1'b0;
        mAck[k] = 1'b1;
      end
    end else if (rd || wr) begin
      cAddr[k] = addr; cData[k] = wdata; cRd[k] = rd; cWr[k] = wr; cBe[k] = be;
      mPend[k] = 1'b1;
      mDue[k] = cyc + ((k == 0) ? WS0 : WS1) + 1;
    end
  endtask

  always @(posedge clk) begin
    modelStep(0);
    modelStep(1);
    cyc++;
  end

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checkEn) begin
      chk("ack0", 32'(ack0), 32'(mAck[0]));
      chk("busy0", 32'(busy0), 32'(mPend[0]));
      chk("err0", 32'(err0), 32'(mErr[0]));
      if (mKnownOut[0]) chk("dout0", dout0, mDout[0]);
      chk("ack1", 32'(ack1), 32'(mAck[1]));
      chk("busy1", 32'(busy1), 32'(mPend[1]));
      chk("err1", 32'(err1), 32'(mErr[1]));
      if (mKnownOut[1]) chk("dout1", dout1, mDout[1]);
    end
  end

  // Full handshake; called just after a negedge, returns just after a negedge.
  task automatic doReq(input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] m, input int hold,
                       output int lat0, output int lat1,
                       output logic e0, output logic e1,
                       output logic [31:0] d0, output logic [31:0] d1);
    rd = r; wr = w; addr = a; wdata = d; be = m;
    lat0 = -1; lat1 = -1;
    for (int n = 1; n <= 50; n++) begin
      @(negedge clk);
      if (ack0 && lat0 < 0) lat0 = n - 1;
      if (ack1 && lat1 < 0) lat1 = n - 1;
      if (lat0 >= 0 && lat1 >= 0) break;
    end
    if (lat0 < 0 || lat1 < 0) begin
      checks++;
      errors++;
      $display("FAIL ackTimeout got lat0=%0d lat1=%0d expected both acked", lat0, lat1);
    end
    e0 = err0; e1 = err1; d0 = dout0; d1 = dout1;
    if (hold > 0) begin
      repeat (hold) @(negedge clk);
      chk("holdAck", {30'd0, ack1, ack0}, 32'd3);
      chk("holdData0", dout0, d0);
    end
    #1;
    rd = 1'b0; wr = 1'b0;
    @(negedge clk);
    chk("ackFall", {30'd0, ack1, ack0}, 32'd0);
    #1;
  endtask

  int          l0, l1;
  logic        e0, e1;
  logic [31:0] d0, d1;

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rstData0", dout0, 32'd0);
    chk("rstCtl0", {29'd0, err0, busy0, ack0}, 32'd0);
    chk("rstCtl1", {29'd0, err1, busy1, ack1}, 32'd0);
    #1 rst_n = 1'b1;
    checkEn = 1'b1;
    @(negedge clk); #1;

    // Write then read back with latency checks.
    doReq(1'b0, 1'b1, 32'h05, 32'hDEADBEEF, 4'hF, 0, l0, l1, e0, e1, d0, d1);
    chk("latency0", 32'(l0), 32'd3);
    chk("latency1", 32'(l1), 32'd1);
    chk("wrErr0", 32'(e0), 32'd0);
    doReq(1'b1, 1'b0, 32'h05, 32'h0, 4'hF, 4, l0, l1, e0, e1, d0, d1);
    chk("rd05_0", d0, 32'hDEADBEEF);
    chk("rd05_1", d1, 32'hDEADBEEF);
    chk("rdErr1", 32'(e1), 32'd0);

    // RD and WR together is rejected; prior contents survive.
    doReq(1'b0, 1'b1, 32'h10, 32'h12345678, 4'hF, 0, l0, l1, e0, e1, d0, d1);
    doReq(1'b1, 1'b1, 32'h10, 32'h87654321, 4'hF, 0, l0, l1, e0, e1, d0, d1);
    chk("bothErr", {30'd0, e1, e0}, 32'd3);
    chk("bothData0", d0, 32'd0);
    doReq(1'b1, 1'b0, 32'h10, 32'h0, 4'hF, 0, l0, l1, e0, e1, d0, d1);
    chk("rd10_0", d0, 32'h12345678);
    chk("rd10_1", d1, 32'h12345678);

    // Out-of-range addresses.
    doReq(1'b0, 1'b1, 32'h100, 32'h0BADF00D, 4'hF, 0, l0, l1, e0, e1, d0, d1);
    chk("addr100Err", {30'd0, e1, e0}, 32'd3);
    doReq(1'b0, 1'b1, 32'hC8, 32'hCAFEF00D, 4'hF, 0, l0, l1, e0, e1, d0, d1);
    chk("addrC8Err", {30'd0, e1, e0}, 32'd2);
    doReq(1'b1, 1'b0, 32'hC8, 32'h0, 4'hF, 0, l0, l1, e0, e1, d0, d1);
    chk("rdC8_0", d0, 32'hCAFEF00D);
    chk("rdC8_1", d1, 32'd0);
    doReq(1'b1, 1'b0, 32'h00, 32'h0, 4'hF, 0, l0, l1, e0, e1, d0, d1);

    // Reset during BUSY aborts the write.
    doReq(1'b0, 1'b1, 32'h07, 32'h11111111, 4'hF, 0, l0, l1, e0, e1, d0, d1);
    rd = 1'b0; wr = 1'b1; addr = 32'h07; wdata = 32'h22222222; be = 4'hF;
    @(negedge clk);
    chk("abortBusy", {30'd0, busy1, busy0}, 32'd3);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("abortCtl", {26'd0, err1, err0, busy1, busy0, ack1, ack0}, 32'd0);
    chk("abortData0", dout0, 32'd0);
    #1 rst_n = 1'b1; wr = 1'b0;
    @(negedge clk); #1;
    doReq(1'b1, 1'b0, 32'h07, 32'h0, 4'hF, 0, l0, l1, e0, e1, d0, d1);
    chk("rd07_0", d0, 32'h11111111);
    chk("rd07_1", d1, 32'h11111111);

`ifdef MAIN_MEMORY_WS_BYTEMASK_EN
    doReq(1'b0, 1'b1, 32'h20, 32'h00000000, 4'hF, 0, l0, l1, e0, e1, d0, d1);
    doReq(1'b0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 0, l0, l1, e0, e1, d0, d1);
    doReq(1'b1, 1'b0, 32'h20, 32'h0, 4'h0, 0, l0, l1, e0, e1, d0, d1);
    chk("mask0101", d0, 32'h00BB00DD);
    doReq(1'b0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, 0, l0, l1, e0, e1, d0, d1);
    doReq(1'b1, 1'b0, 32'h20, 32'h0, 4'hF, 0, l0, l1, e0, e1, d0, d1);
    chk("maskNone", d1, 32'h00BB00DD);
`endif

    // Randomized level-driven traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk); #1;
      if ($urandom_range(0, 399) == 0) begin
        rst_n = 1'b0;
        @(negedge clk); #1;
        rst_n = 1'b1;
      end
      if ($urandom_range(0, 3) == 0) begin
        int r, sel;
        r = $urandom_range(0, 9);
        rd = (r < 4);
        wr = (r >= 3) && (r < 7);
        sel = $urandom_range(0, 9);
        if (sel < 8) addr = 32'($urandom_range(0, 15));
        else if (sel == 8) addr = 32'($urandom_range(190, 255));
        else addr = 32'h100 + 32'($urandom_range(0, 3));
        wdata = $urandom;
        be = 4'($urandom_range(0, 15));
      end
    end
    rd = 1'b0; wr = 1'b0;
    repeat (10) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
